umips_id_ex: RTL and testbench

UMIPS_ID_EX -- requirements
Module: umips_id_ex

---
 rtl/umips_id_ex.sv | 110 +++++++++++
 tb/tb_umips_id_ex.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/umips_id_ex.sv
// ID/EX pipeline register for the micro-MIPS core: one-entry skid-free holding stage
// with MEM/WB operand forwarding on capture and WB snooping while stalled.
module umips_id_ex #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [3:0]    id_op,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic          id_wen,
    input  logic          mem_wen,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_val,
    input  logic          wb_wen,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_val,
    input  logic          flush,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [RW-1:0] ex_rd,
    output logic          ex_wen,
    output logic [DW-1:0] ex_rt_val
);

    logic          valid_q;
    logic          wen_q;
    logic          use_imm_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic          transfer;
    logic          snoop_rs;
    logic          snoop_rt;

    assign id_ready = !valid_q || ex_ready;
    assign transfer = id_valid && id_ready && !flush;
    assign ex_valid = valid_q;
    assign ex_wen   = wen_q && valid_q;

    // MEM result is younger than WB, so it wins when both target the same register.
    always_comb begin
        fwd_rs = id_rs_val;
        if (id_rs != '0 && mem_wen && mem_rd == id_rs)
            fwd_rs = mem_val;
        else if (id_rs != '0 && wb_wen && wb_rd == id_rs)
            fwd_rs = wb_val;

        fwd_rt = id_rt_val;
        if (id_rt != '0 && mem_wen && mem_rd == id_rt)
            fwd_rt = mem_val;
        else if (id_rt != '0 && wb_wen && wb_rd == id_rt)
            fwd_rt = wb_val;
    end

    assign snoop_rs = wb_wen && rs_q != '0 && wb_rd == rs_q;
    assign snoop_rt = wb_wen && rt_q != '0 && wb_rd == rt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            ex_rd     <= '0;
            wen_q     <= 1'b0;
            ex_rt_val <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            use_imm_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (transfer) begin
            valid_q   <= 1'b1;
            alu_op    <= id_op;
            alu_a     <= fwd_rs;
            alu_b     <= id_use_imm ? id_imm : fwd_rt;
            ex_rd     <= id_rd;
            wen_q     <= id_wen;
            ex_rt_val <= fwd_rt;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            use_imm_q <= id_use_imm;
        end else if (valid_q && ex_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Stalled: a producer retiring through WB would otherwise be lost to us.
            if (snoop_rs)
                alu_a <= wb_val;
            if (snoop_rt) begin
                ex_rt_val <= wb_val;
                if (!use_imm_q)
                    alu_b <= wb_val;
            end
        end
    end

endmodule

// File: tb/tb_umips_id_ex.sv
// Bench for umips_id_ex: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an instruction-level model.
module tb_umips_id_ex;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam logic [3:0] ALU_ADD = 4'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_ready;
    logic [3:0]    id_op;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_val, id_rt_val, id_imm;
    logic          id_use_imm, id_wen;
    logic          mem_wen, wb_wen;
    logic [RW-1:0] mem_rd, wb_rd;
    logic [DW-1:0] mem_val, wb_val;
    logic          flush, ex_ready;
    logic          ex_valid, ex_wen;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b, ex_rt_val;
    logic [RW-1:0] ex_rd;

    umips_id_ex #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_wen(id_wen),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_val(mem_val),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_val(wb_val),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_rt_val(ex_rt_val)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model: the one instruction (if any) sitting in EX, as the ISA sees it.
    bit            m_valid;
    logic [3:0]    m_op;
    logic [RW-1:0] m_rs, m_rt, m_rd;
    bit            m_wen, m_use_imm;
    logic [DW-1:0] m_imm, m_a, m_rt_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] operand(input logic [RW-1:0] r, input logic [DW-1:0] v);
        if (r != 0 && mem_wen && mem_rd == r) return mem_val;
        if (r != 0 && wb_wen && wb_rd == r) return wb_val;
        return v;
    endfunction

    function automatic logic [DW-1:0] m_b();
        return m_use_imm ? m_imm : m_rt_val;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_wen = 0; m_use_imm = 0; m_imm = 0; m_a = 0; m_rt_val = 0;
    endtask

    task automatic model_edge();
        bit can_take;
        can_take = !m_valid || ex_ready;
        if (flush) begin
            m_valid = 0;
        end else if (id_valid && can_take) begin
            m_valid = 1; m_op = id_op; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_wen = id_wen; m_use_imm = id_use_imm; m_imm = id_imm;
            m_a = operand(id_rs, id_rs_val);
            m_rt_val = operand(id_rt, id_rt_val);
        end else if (m_valid && ex_ready) begin
            m_valid = 0;
        end else if (m_valid) begin
            if (wb_wen && m_rs != 0 && wb_rd == m_rs) m_a = wb_val;
            if (wb_wen && m_rt != 0 && wb_rd == m_rt) m_rt_val = wb_val;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("ex_valid", ex_valid, m_valid);
            chk("id_ready", id_ready, !m_valid || ex_ready);
            chk("alu_op", alu_op, m_op);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b());
            chk("ex_rd", ex_rd, m_rd);
            chk("ex_wen", ex_wen, m_wen && m_valid);
            chk("ex_rt_val", ex_rt_val, m_rt_val);
        end
    end

    task automatic clr_inputs();
        id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_use_imm = 0; id_wen = 0;
        mem_wen = 0; mem_rd = 0; mem_val = 0; wb_wen = 0; wb_rd = 0; wb_val = 0;
        flush = 0; ex_ready = 0;
    endtask

    // One clock: model follows the edge, then return just after the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [RW-1:0] rs, input logic [DW-1:0] rsv,
                             input logic [RW-1:0] rt, input logic [DW-1:0] rtv);
        id_valid = 1; id_op = ALU_ADD; id_rs = rs; id_rs_val = rsv;
        id_rt = rt; id_rt_val = rtv; id_rd = 5'd2; id_wen = 1;
    endtask

    initial begin
        clr_inputs();
        model_reset();
        rst = 1;
        #12;
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_id_ready", id_ready, 1);
        chk("reset_alu_a", alu_a, 0);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        #1;

        // Plain capture, no forwarding
        set_instr(5'd3, 32'd5, 5'd4, 32'd7);
        ex_ready = 1;
        step();
        chk("add_ex_valid", ex_valid, 1);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);

        // MEM beats WB; r0 never forwarded
        set_instr(5'd3, 32'd1, 5'd4, 32'd7);
        mem_wen = 1; mem_rd = 5'd3; mem_val = 32'hAA;
        wb_wen = 1; wb_rd = 5'd3; wb_val = 32'hBB;
        step();
        chk("fwd_mem_prio", alu_a, 32'hAA);
        set_instr(5'd0, 32'h11, 5'd4, 32'd7);
        mem_rd = 5'd0; wb_rd = 5'd0;
        step();
        chk("fwd_r0", alu_a, 32'h11);

        // Stall with WB snoop, immediate operand B
        clr_inputs();
        set_instr(5'd6, 32'd1, 5'd7, 32'd9);
        id_use_imm = 1; id_imm = 32'h99; ex_ready = 1;
        step();
        chk("snoop_pre_a", alu_a, 32'd1);
        set_instr(5'd8, 32'd3, 5'd9, 32'd4);
        ex_ready = 0; wb_wen = 1; wb_rd = 5'd6; wb_val = 32'h55;
        #1;
        chk("snoop_id_ready", id_ready, 0);
        step();
        chk("snoop_alu_a", alu_a, 32'h55);
        chk("snoop_alu_b_imm", alu_b, 32'h99);

        // Back-to-back throughput
        clr_inputs();
        ex_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_instr(5'd1, 32'(100 + i), 5'd2, 32'd0);
            #1;
            chk("b2b_id_ready", id_ready, 1);
            step();
            chk("b2b_ex_valid", ex_valid, 1);
            chk("b2b_alu_a", alu_a, 32'(100 + i));
        end

        // Flush dominates
        set_instr(5'd1, 32'd1, 5'd2, 32'd2);
        ex_ready = 0; flush = 1;
        step();
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_ex_wen", ex_wen, 0);
        clr_inputs();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid   = ($urandom_range(0, 9) < 7);
            id_op      = 4'($urandom);
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 31));
            id_rs_val  = $urandom;
            id_rt_val  = $urandom;
            id_imm     = $urandom;
            id_use_imm = 1'($urandom);
            id_wen     = 1'($urandom);
            mem_wen    = 1'($urandom);
            mem_rd     = 5'($urandom_range(0, 7));
            mem_val    = $urandom;
            wb_wen     = 1'($urandom);
            wb_rd      = 5'($urandom_range(0, 7));
            wb_val     = $urandom;
            flush      = ($urandom_range(0, 9) == 0);
            ex_ready   = ($urandom_range(0, 9) < 6);
            step();
        end

        // Asynchronous reset in the middle of a stall
        clr_inputs();
        set_instr(5'd5, 32'h1234, 5'd6, 32'h5678);
        ex_ready = 1;
        step();
        id_valid = 0; ex_ready = 0;
        step();
        chk("stall_before_rst", ex_valid, 1);
        rst = 1;
        model_reset();
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rt_val", ex_rt_val, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_ex_wen", ex_wen, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_id_ready", id_ready, 1);
        @(negedge clk);
        rst = 0;
        #1;
        step();
        chk("post_rst_ready", id_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
